imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//   Parametrised, registered immediate-extension stage for the MIPS datapath.
//   Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper, or branch-offset.
//   Sits between decode and the ALU operand mux behind a valid/ready skid buffer, so it gives full throughput and no combinational ready path.
//   A wrapping transfer counter gives the bench and debug logic visibility.
// PARAMETERS
//   IN_W   16  immediate input width; must be >= 2
//   OUT_W  32  extended output width; must be > IN_W
//   CNT_W  16  width of the transfer counter xfer_count
// PORTS
//   clk         input   1      rising-edge clock; the single clock domain
//   rst_n       input   1      synchronous, active-low reset
//   in_valid    input   1      upstream has an immediate on input_data/mode
//   in_ready    output  1      block can accept an input this cycle
//   input_data  input   IN_W   raw immediate
//   mode        input   2      00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//   out_valid   output  1      output_data holds a result
//   out_ready   input   1      downstream accepts the result this cycle
//   output_data output  OUT_W  extended result
//   xfer_count  output  CNT_W  count of completed output transfers (wraps)
// BEHAVIOUR
//   Arithmetic (ext = f(input_data, mode), truncated to OUT_W):
//   - 00: {(OUT_W-IN_W){1'b0}, input_data}
//   - 01: {(OUT_W-IN_W){input_data[IN_W-1]}, input_data}
//   - 10: {input_data, (OUT_W-IN_W){1'b0}} (LUI form)
//   - 11: sign-extended value << 2; bits shifted past OUT_W-1 are dropped; bits [1:0] = 0.
//   Handshake:
//   - Input transfer occurs when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - Upstream must hold input_data and mode stable while in_valid & !in_ready.
//   - output_data and out_valid stay stable while out_valid & !out_ready.
//   - in_ready is a register output equal to !skid_valid; no combinational path from out_ready.
//   Storage: one main register (drives outputs) and one skid register; ext is computed before storage.
//   State machine:
//   - EMPTY -> FULL1 on input transfer.
//   - FULL1 -> FULL1 on input and output together (main reloads).
//   - FULL1 -> EMPTY on output only.
//   - FULL1 -> FULL2 on input with out_valid & !out_ready (input goes to skid; in_ready drops next cycle).
//   - FULL2 -> FULL1 on output transfer (skid moves to main); no input is accepted in FULL2.
//   - Ordering is strictly FIFO.
//   Latency: 1 cycle from input transfer to out_valid when the stage is empty.
//   Throughput: one result per cycle with out_ready held high.
//   xfer_count: +1 on every output transfer; wraps from 2^CNT_W-1 to 0.
//   Reset (rst_n low at a clock edge):
//   - out_valid=0, output_data=0, skid emptied, in_ready=1, xfer_count=0, state=EMPTY.
//   - Inputs are ignored on that edge.
//   - Mid-operation reset discards main and skid contents with no output transfer.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles -> out_valid=0, output_data=0, in_ready=1, xfer_count=0.
//   2 Modes, out_ready=1, defaults; one result per cycle, each 1 cycle after input:
//     - mode 01: 0x0001 -> 0x00000001; 0xFFFF -> 0xFFFFFFFF; 0x8000 -> 0xFFFF8000
//     - mode 00: 0x8000 -> 0x00008000
//     - mode 10: 0x1234 -> 0x12340000
//     - mode 11: 0xFFFF -> 0xFFFFFFFC; 0x4000 -> 0x00010000
//   3 Backpressure:
//     - out_ready=0; send A=0x0001 then B=0x0002 (mode 01).
//     - Required: in_ready=0 the cycle after B; C is held; output stays A until out_ready=1.
//     - Then A, B, C drain in order; xfer_count ends at 3.
//   4 Streaming: 100 back-to-back inputs with out_ready=1 -> 100 outputs in 100 consecutive cycles; in_ready never drops.
//   5 Reset mid-operation: in FULL2, pulse rst_n=0 for 1 cycle -> out_valid=0 and in_ready=1 next cycle; no stale data appears afterwards.
//   6 Wrap: CNT_W=4; 17 transfers -> xfer_count reads 1.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage (zero/sign/upper/branch-offset) behind a
// two-entry valid/ready skid buffer, with a wrapping output-transfer counter.
//
// state  | meaning
// EMPTY  | no result held; out_valid=0, in_ready=1
// FULL1  | main register holds a result; skid empty; in_ready=1
// FULL2  | main and skid both hold results; in_ready=0
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  input_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] output_data,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL1 = 2'd1,
        S_FULL2 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   main_q, main_d;
    logic [OUT_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;
    logic [OUT_W-1:0]   ext;
    logic               push, pop;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                                input logic [1:0]      m);
        logic [OUT_W-1:0] sx;
        sx = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
        case (m)
            2'b00:   extend = {{(OUT_W-IN_W){1'b0}}, d};
            2'b01:   extend = sx;
            2'b10:   extend = {d, {(OUT_W-IN_W){1'b0}}};
            default: extend = sx << 2;
        endcase
    endfunction

    assign ext  = extend(input_data, mode);
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (push) state_d = S_FULL1;
            S_FULL1: begin
                if (push && !pop)      state_d = S_FULL2;
                else if (!push && pop) state_d = S_EMPTY;
            end
            S_FULL2: if (pop) state_d = S_FULL1;
            default: state_d = S_EMPTY;
        endcase
    end

    // Both handshake outputs decode only the state register, so ready never
    // depends combinationally on out_ready.
    always_comb begin
        in_ready  = (state_q != S_FULL2);
        out_valid = (state_q != S_EMPTY);
    end

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        xfer_count_d = xfer_count_q + (pop ? CNT_W'(1) : CNT_W'(0));
        case (state_q)
            S_EMPTY: if (push) main_d = ext;
            S_FULL1: begin
                if (push && pop) main_d = ext;
                else if (push)   skid_d = ext;
            end
            S_FULL2: if (pop) main_d = skid_q;
            default: ;
        endcase
    end

    assign output_data = main_q;
    assign xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a queue-based reference model checked every cycle,
// plus directed literal checks; a CNT_W=4 twin exercises counter wrap.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] input_data;
    logic [1:0]  mode;
    logic        out_ready;

    logic        in_ready,  out_valid;
    logic [31:0] output_data;
    logic [15:0] xfer_count;
    logic        in_ready4, out_valid4;
    logic [31:0] output_data4;
    logic [3:0]  xfer_count4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mq[$];
    int unsigned mcnt;
    bit          m_accepted;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .input_data(input_data), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .output_data(output_data), .xfer_count(xfer_count)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .input_data(input_data), .mode(mode), .out_valid(out_valid4),
        .out_ready(out_ready), .output_data(output_data4), .xfer_count(xfer_count4)
    );

    function automatic logic [31:0] model_ext(input logic [15:0] d, input logic [1:0] m);
        longint s;
        s = d[15] ? longint'(d) - 65536 : longint'(d);
        case (m)
            2'd0:    return 32'(d);
            2'd1:    return 32'(s);
            2'd2:    return 32'(longint'(d) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mcnt       = 0;
            m_accepted = 1'b0;
        end else begin
            bit p_pop, p_push;
            p_pop  = (mq.size() > 0) && out_ready;
            p_push = in_valid && (mq.size() < 2);
            if (p_pop) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (p_push) mq.push_back(model_ext(input_data, mode));
            m_accepted = p_push;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",   32'(in_ready),   32'(mq.size() < 2));
            chk("out_valid",  32'(out_valid),  32'(mq.size() > 0));
            chk("xfer_count", 32'(xfer_count), 32'(mcnt[15:0]));
            chk("xfer_count4", 32'(xfer_count4), 32'(mcnt[3:0]));
            chk("out_valid4", 32'(out_valid4), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("output_data",  output_data,  mq[0]);
                chk("output_data4", output_data4, mq[0]);
            end
        end
    end

    task automatic cycle(input bit v, input logic [15:0] d, input logic [1:0] m,
                         input bit ordy, input bit rn);
        in_valid   = v;
        input_data = d;
        mode       = m;
        out_ready  = ordy;
        rst_n      = rn;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] td[7];
    logic [1:0]  tm[7];
    logic [31:0] te[7];

    initial begin
        bit dropped, gap, cur_v;
        logic [15:0] cur_d;
        logic [1:0]  cur_m;

        td = '{16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
        tm = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
        te = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFF8000, 32'h00008000,
               32'h12340000, 32'hFFFFFFFC, 32'h00010000};

        // Reset, with inputs active to show they are ignored
        cycle(1, 16'hAAAA, 2'd1, 1, 0);
        cycle(1, 16'hAAAA, 2'd1, 1, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_output_data", output_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_xfer_count", 32'(xfer_count), 32'd0);
        chk_en = 1'b1;

        // Extension modes, one result per cycle
        for (int i = 0; i < 7; i++) begin
            cycle(1, td[i], tm[i], 1, 1);
            chk("mode_valid", 32'(out_valid), 32'd1);
            chk("mode_data", output_data, te[i]);
        end

        // Backpressure
        cycle(0, 16'h0, 2'd0, 1, 0);
        cycle(1, 16'h0001, 2'd1, 0, 1);
        chk("bp_a_held", output_data, 32'h1);
        cycle(1, 16'h0002, 2'd1, 0, 1);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        cycle(1, 16'h0003, 2'd1, 0, 1);
        chk("bp_still_a", output_data, 32'h1);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        cycle(1, 16'h0003, 2'd1, 1, 1);
        chk("bp_b", output_data, 32'h2);
        cycle(1, 16'h0003, 2'd1, 1, 1);
        chk("bp_c", output_data, 32'h3);
        cycle(0, 16'h0, 2'd0, 1, 1);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(xfer_count), 32'd3);

        // Streaming
        cycle(0, 16'h0, 2'd0, 1, 0);
        dropped = 0;
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1, 16'($urandom), 2'($urandom_range(0, 3)), 1, 1);
            if (!in_ready) dropped = 1;
            if (!out_valid) gap = 1;
        end
        cycle(0, 16'h0, 2'd0, 1, 1);
        chk("stream_in_ready_drop", 32'(dropped), 32'd0);
        chk("stream_gap", 32'(gap), 32'd0);
        chk("stream_count", 32'(xfer_count), 32'd100);
        chk("stream_count4", 32'(xfer_count4), 32'd4);

        // Reset while FULL2
        cycle(0, 16'h0, 2'd0, 1, 0);
        cycle(1, 16'h0005, 2'd0, 0, 1);
        cycle(1, 16'h0006, 2'd0, 0, 1);
        chk("full2_reached", 32'(in_ready), 32'd0);
        cycle(1, 16'h0007, 2'd0, 0, 0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 16'h0, 2'd0, 1, 1);
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("midrst_count", 32'(xfer_count), 32'd0);

        // Counter wrap on the 4-bit instance
        cycle(0, 16'h0, 2'd0, 1, 0);
        for (int i = 0; i < 17; i++) cycle(1, 16'(i), 2'd0, 1, 1);
        cycle(0, 16'h0, 2'd0, 1, 1);
        chk("wrap_count4", 32'(xfer_count4), 32'd1);
        chk("wrap_count16", 32'(xfer_count), 32'd17);

        // Random traffic with held inputs under backpressure and rare resets
        cur_v = 0;
        cur_d = '0;
        cur_m = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(cur_v && !m_accepted)) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = 16'($urandom);
                cur_m = 2'($urandom_range(0, 3));
            end
            cycle(cur_v, cur_d, cur_m, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 199) != 0));
            if (!rst_n) cur_v = 0;
        end
        cycle(0, 16'h0, 2'd0, 1, 1);
        cycle(0, 16'h0, 2'd0, 1, 1);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
